// File: rtl/alu_mc_pkg.sv
// Shared types for the alu_mc execute unit: opcode encoding, FSM states, decode helpers.
// Optional divider is enabled by defining ALU_MC_DIV_EN.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_SLL    = 5'h02,
    OP_SLT    = 5'h03,
    OP_SLTU   = 5'h04,
    OP_XOR    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_OR     = 5'h08,
    OP_AND    = 5'h09,
    OP_LUI    = 5'h0A,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_mc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4] & ~op[3];
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return is_muldiv(op) & op[2];
  endfunction

endpackage

// File: rtl/alu_mc_mul_div_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider, one step per cycle for XLEN cycles.
// Divider steps exist only when ALU_MC_DIV_EN is defined.
module alu_mc_mul_div_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done_c,
  output logic [XLEN-1:0] o_result_c
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi, r_lo, r_b;
  logic             r_neg, r_sel_hi;
  logic             w_a_sgn, w_b_sgn, w_neg, w_sel_hi;
  logic [XLEN-1:0]  w_a_mag, w_b_mag, w_hi_nxt, w_lo_nxt;
  logic [XLEN:0]    w_sum;
  logic [PW-1:0]    w_prod;
`ifdef ALU_MC_DIV_EN
  logic             r_div;
  logic [XLEN:0]    w_shift, w_diff;
`endif

  // Operand signs become magnitudes; r_neg marks the final correction needed
  always_comb begin
    w_a_sgn  = 1'b0;
    w_b_sgn  = 1'b0;
    w_neg    = 1'b0;
    w_sel_hi = 1'b1;
    case (i_op)
      OP_MUL:    w_sel_hi = 1'b0;
      OP_MULH:   begin w_a_sgn = i_a[XLEN-1]; w_b_sgn = i_b[XLEN-1]; w_neg = w_a_sgn ^ w_b_sgn; end
      OP_MULHSU: begin w_a_sgn = i_a[XLEN-1]; w_neg = w_a_sgn; end
      OP_DIV:    begin w_a_sgn = i_a[XLEN-1]; w_b_sgn = i_b[XLEN-1]; w_neg = w_a_sgn ^ w_b_sgn;
                       w_sel_hi = 1'b0; end
      OP_DIVU:   w_sel_hi = 1'b0;
      OP_REM:    begin w_a_sgn = i_a[XLEN-1]; w_b_sgn = i_b[XLEN-1]; w_neg = w_a_sgn; end
      default:   ;
    endcase
    w_a_mag = w_a_sgn ? (~i_a + XLEN'(1)) : i_a;
    w_b_mag = w_b_sgn ? (~i_b + XLEN'(1)) : i_b;
  end

  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    w_hi_nxt = w_sum[XLEN:1];
    w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    w_prod   = {w_hi_nxt, w_lo_nxt};
    if (r_neg) w_prod = ~w_prod + PW'(1);
    o_result_c = r_sel_hi ? w_prod[PW-1:XLEN] : w_prod[XLEN-1:0];
`ifdef ALU_MC_DIV_EN
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_div) begin
      if (!w_diff[XLEN]) begin
        w_hi_nxt = w_diff[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
      o_result_c = r_sel_hi ? w_hi_nxt : w_lo_nxt;
      if (r_neg) o_result_c = ~o_result_c + XLEN'(1);
    end
`endif
  end

  assign o_done_c = r_busy & (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_sel_hi <= 1'b0;
`ifdef ALU_MC_DIV_EN
      r_div    <= 1'b0;
`endif
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= w_a_mag;
      r_b      <= w_b_mag;
      r_neg    <= w_neg;
      r_sel_hi <= w_sel_hi;
`ifdef ALU_MC_DIV_EN
      r_div    <= is_div(i_op);
`endif
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_done_c) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX unit: 1-cycle base ALU ops plus iterative RV M-extension with valid/ready handshake.
// Define ALU_MC_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU report illegal_op.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal_op
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  state_e             r_state;
  logic               w_accept, w_long, w_illegal, w_md_done;
  logic [XLEN-1:0]    w_fast_res, w_md_res;
  logic [SHAMT_W-1:0] w_shamt;

  assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_shamt  = operand_b[SHAMT_W-1:0];

  // Single-cycle results, divider corner cases, and long-op detection
  always_comb begin
    w_fast_res = '0;
    w_illegal  = 1'b0;
    w_long     = 1'b0;
    case (op)
      OP_ADD:  w_fast_res = operand_a + operand_b;
      OP_SUB:  w_fast_res = operand_a - operand_b;
      OP_SLL:  w_fast_res = operand_a << w_shamt;
      OP_SLT:  w_fast_res = XLEN'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: w_fast_res = XLEN'(operand_a < operand_b);
      OP_XOR:  w_fast_res = operand_a ^ operand_b;
      OP_SRL:  w_fast_res = operand_a >> w_shamt;
      OP_SRA:  w_fast_res = XLEN'($signed(operand_a) >>> w_shamt);
      OP_OR:   w_fast_res = operand_a | operand_b;
      OP_AND:  w_fast_res = operand_a & operand_b;
      OP_LUI:  w_fast_res = operand_b;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_long = is_muldiv(op);
`ifdef ALU_MC_DIV_EN
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        if (operand_b == '0) begin
          w_fast_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : operand_a;
        end else if (((op == OP_DIV) || (op == OP_REM)) && (operand_b == '1) &&
                     (operand_a == {1'b1, {(XLEN-1){1'b0}}})) begin
          w_fast_res = (op == OP_DIV) ? operand_a : '0;
        end else begin
          w_long = 1'b1;
        end
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  alu_mc_mul_div_iter #(.XLEN(XLEN)) u_mul_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept & w_long),
    .i_op       (op),
    .i_a        (operand_a),
    .i_b        (operand_b),
    .o_done_c   (w_md_done),
    .o_result_c (w_md_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      illegal_op <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_long) begin
              r_state   <= ST_BUSY;
              out_valid <= 1'b0;
            end else begin
              r_state    <= ST_DONE;
              out_valid  <= 1'b1;
              result     <= w_fast_res;
              illegal_op <= w_illegal;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_md_done) begin
            r_state    <= ST_DONE;
            out_valid  <= 1'b1;
            result     <= w_md_res;
            illegal_op <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (XLEN=32): base ops, mul/div latency and values, reset abort, output hold.
// Divider expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, illegal_op;
  logic [4:0]  op;
  logic [31:0] operand_a, operand_b, result;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .illegal_op (illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] res,
                        input logic ill);
    int n;
    @(negedge clk);
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    in_valid = 1'b0; op = 5'h1F; operand_a = $urandom; operand_b = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(lat));
    chk({tag, "/result"}, result, res);
    chk({tag, "/illegal"}, 32'(illegal_op), 32'(ill));
  endtask

  initial begin
    int n;
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; operand_a = '0; operand_b = '0;
    @(negedge clk);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/result", result, 32'd0);
    chk("reset/illegal", 32'(illegal_op), 32'd0);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Base ops
    run_op("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'h1,        1, 32'h0,        1'b0);
    run_op("sub",      OP_SUB,  32'h3,        32'h5,        1, 32'hFFFFFFFE, 1'b0);
    run_op("sll_mask", OP_SLL,  32'h1,        32'h21,       1, 32'h2,        1'b0);
    run_op("srl",      OP_SRL,  32'h80000000, 32'h1F,       1, 32'h1,        1'b0);
    run_op("sra",      OP_SRA,  32'h80000000, 32'h4,        1, 32'hF8000000, 1'b0);
    run_op("slt",      OP_SLT,  32'h1,        32'h80000000, 1, 32'h0,        1'b0);
    run_op("sltu",     OP_SLTU, 32'h1,        32'hFFFFFFFF, 1, 32'h1,        1'b0);
    run_op("xor",      OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0FF00FF0, 1'b0);
    run_op("or",       OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hFFF0FFF0, 1'b0);
    run_op("and",      OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 1'b0);
    run_op("lui",      OP_LUI,  32'hDEADBEEF, 32'h12345000, 1, 32'h12345000, 1'b0);
    run_op("ill_0c",   5'h0C,   32'h5,        32'h6,        1, 32'h0,        1'b1);
    run_op("ill_1f",   5'h1F,   32'h5,        32'h6,        1, 32'h0,        1'b1);

    // Back-to-back: ADD then SLT with no bubble
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; operand_a = 32'hFFFFFFFF; operand_b = 32'h1;
    @(negedge clk);
    chk("b2b/add_valid", 32'(out_valid), 32'd1);
    chk("b2b/add_result", result, 32'h0);
    chk("b2b/in_ready", 32'(in_ready), 32'd1);
    op = OP_SLT; operand_a = 32'h80000000; operand_b = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b/slt_valid", 32'(out_valid), 32'd1);
    chk("b2b/slt_result", result, 32'h1);

    // Multiply
    run_op("mul",       OP_MUL,    32'd7,        32'd6,        33, 32'd42,       1'b0);
    run_op("mul_low",   OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h1,        1'b0);
    run_op("mulh_min",  OP_MULH,   32'h80000000, 32'h80000000, 33, 32'h40000000, 1'b0);
    run_op("mulh_m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h0,        1'b0);
    run_op("mulhsu",    OP_MULHSU, 32'hFFFFFFFF, 32'h2,        33, 32'hFFFFFFFF, 1'b0);
    run_op("mulhu",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 1'b0);

    // Divide
`ifdef ALU_MC_DIV_EN
    run_op("div_neg",   OP_DIV,  32'hFFFFFFF9, 32'h2,        33, 32'hFFFFFFFD, 1'b0);
    run_op("rem_neg",   OP_REM,  32'hFFFFFFF9, 32'h2,        33, 32'hFFFFFFFF, 1'b0);
    run_op("div_negb",  OP_DIV,  32'h7,        32'hFFFFFFFE, 33, 32'hFFFFFFFD, 1'b0);
    run_op("rem_negb",  OP_REM,  32'h7,        32'hFFFFFFFE, 33, 32'h1,        1'b0);
    run_op("divu",      OP_DIVU, 32'd100,      32'd7,        33, 32'd14,       1'b0);
    run_op("remu",      OP_REMU, 32'd100,      32'd7,        33, 32'd2,        1'b0);
    run_op("divu_big",  OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        1'b0);
    run_op("divu_z",    OP_DIVU, 32'd5,        32'd0,        1,  32'hFFFFFFFF, 1'b0);
    run_op("rem_z",     OP_REM,  32'd5,        32'd0,        1,  32'd5,        1'b0);
    run_op("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000, 1'b0);
    run_op("rem_ovf",   OP_REM,  32'h80000000, 32'hFFFFFFFF, 1,  32'h0,        1'b0);
`else
    run_op("div_ill",   OP_DIV,  32'hFFFFFFF9, 32'h2,        1,  32'h0,        1'b1);
    run_op("rem_ill",   OP_REM,  32'hFFFFFFF9, 32'h2,        1,  32'h0,        1'b1);
    run_op("divu_ill",  OP_DIVU, 32'd5,        32'd0,        1,  32'h0,        1'b1);
    run_op("remu_ill",  OP_REMU, 32'd100,      32'd7,        1,  32'h0,        1'b1);
`endif

    // Reset aborts a multiply in flight
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; operand_a = 32'd7; operand_b = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort/busy_in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort/out_valid", 32'(out_valid), 32'd0);
    chk("abort/in_ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort/no_result", 32'(n), 32'd0);

    // Output held while consumer stalls
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = OP_MULHU; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold/latency", 32'(n), 32'd33);
    chk("hold/result", result, 32'hFFFFFFFE);
    held = 32'hFFFFFFFE;
    in_valid = 1'b1; op = OP_ADD; operand_a = 32'h1; operand_b = 32'h1;
    repeat (10) begin
      @(negedge clk);
      chk("hold/out_valid", 32'(out_valid), 32'd1);
      chk("hold/result_stable", result, held);
      chk("hold/in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hold/release", 32'(out_valid), 32'd0);
    chk("hold/idle_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
